// File: rtl/processor_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : processor_32_bit
// Purpose  : 32-bit five-stage (IF/ID/EX/MEM/WB) pipelined RISC core with a
//            unified word-addressed instruction/data memory and a 32x32
//            register file. Runs a preloaded program until HLT retires.
// Ports    : clk1   - system clock, all state updates on its rising edge
//            rst_n  - asynchronous active-low reset (pipeline flush only;
//                     register file and memory keep their contents)
//            halted - high once a HLT instruction has retired
// Revision : 1.0 - initial release
// ============================================================================
module processor_32_bit #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] PC_RESET  = 32'd0
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int c_AW = $clog2(MEM_DEPTH);

  // Opcodes
  localparam logic [5:0] c_OP_ADD   = 6'b000000;
  localparam logic [5:0] c_OP_SUB   = 6'b000001;
  localparam logic [5:0] c_OP_AND   = 6'b000010;
  localparam logic [5:0] c_OP_OR    = 6'b000011;
  localparam logic [5:0] c_OP_SLT   = 6'b000100;
  localparam logic [5:0] c_OP_MUL   = 6'b000101;
  localparam logic [5:0] c_OP_LW    = 6'b001000;
  localparam logic [5:0] c_OP_SW    = 6'b001001;
  localparam logic [5:0] c_OP_ADDI  = 6'b001010;
  localparam logic [5:0] c_OP_SUBI  = 6'b001011;
  localparam logic [5:0] c_OP_SLTI  = 6'b001100;
  localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
  localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
  localparam logic [5:0] c_OP_HLT   = 6'b111111;

  // Instruction classes carried down the pipe
  localparam logic [2:0] c_T_NOP = 3'd0;
  localparam logic [2:0] c_T_RR  = 3'd1;
  localparam logic [2:0] c_T_RI  = 3'd2;
  localparam logic [2:0] c_T_LD  = 3'd3;
  localparam logic [2:0] c_T_ST  = 3'd4;
  localparam logic [2:0] c_T_BR  = 3'd5;
  localparam logic [2:0] c_T_HLT = 3'd6;

  // ALU functions; codes equal the low three bits of the RR opcodes
  localparam logic [2:0] c_F_ADD = 3'd0;
  localparam logic [2:0] c_F_SUB = 3'd1;
  localparam logic [2:0] c_F_AND = 3'd2;
  localparam logic [2:0] c_F_OR  = 3'd3;
  localparam logic [2:0] c_F_SLT = 3'd4;
  localparam logic [2:0] c_F_MUL = 3'd5;

  // Undefined opcode 111110: decodes as a bubble
  localparam logic [31:0] c_NOP_IR = 32'hF800_0000;

  // Architectural state (names kept for external preload/inspection)
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // Pipeline registers
  logic [31:0] r_ifid_ir, r_ifid_npc;
  logic [2:0]  r_idex_type, r_idex_func;
  logic        r_idex_bnez, r_idex_use_imm;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dst;
  logic [31:0] r_idex_a, r_idex_b, r_idex_imm, r_idex_npc;
  logic [2:0]  r_exmem_type;
  logic [4:0]  r_exmem_dst;
  logic [31:0] r_exmem_alu, r_exmem_b;
  logic        r_exmem_cond;
  logic [2:0]  r_memwb_type;
  logic [4:0]  r_memwb_dst;
  logic [31:0] r_memwb_alu, r_memwb_lmd;

  // ID stage decode
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dst;
  logic [31:0] w_id_imm, w_id_a, w_id_b;
  logic [2:0]  w_id_type, w_id_func;
  logic        w_id_use_imm, w_id_use_rs, w_id_use_rt;

  assign w_id_op  = r_ifid_ir[31:26];
  assign w_id_rs  = r_ifid_ir[25:21];
  assign w_id_rt  = r_ifid_ir[20:16];
  assign w_id_rd  = r_ifid_ir[15:11];
  assign w_id_imm = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};

  always_comb begin
    w_id_type    = c_T_NOP;
    w_id_func    = c_F_ADD;
    w_id_dst     = 5'd0;
    w_id_use_imm = 1'b0;
    w_id_use_rs  = 1'b0;
    w_id_use_rt  = 1'b0;
    case (w_id_op)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT, c_OP_MUL: begin
        w_id_type   = c_T_RR;
        w_id_func   = w_id_op[2:0];
        w_id_dst    = w_id_rd;
        w_id_use_rs = 1'b1;
        w_id_use_rt = 1'b1;
      end
      c_OP_ADDI, c_OP_SUBI, c_OP_SLTI: begin
        w_id_type    = c_T_RI;
        w_id_func    = (w_id_op == c_OP_ADDI) ? c_F_ADD :
                       (w_id_op == c_OP_SUBI) ? c_F_SUB : c_F_SLT;
        w_id_dst     = w_id_rt;
        w_id_use_imm = 1'b1;
        w_id_use_rs  = 1'b1;
      end
      c_OP_LW: begin
        w_id_type    = c_T_LD;
        w_id_dst     = w_id_rt;
        w_id_use_imm = 1'b1;
        w_id_use_rs  = 1'b1;
      end
      c_OP_SW: begin
        w_id_type    = c_T_ST;
        w_id_use_imm = 1'b1;
        w_id_use_rs  = 1'b1;
        w_id_use_rt  = 1'b1;
      end
      c_OP_BNEQZ, c_OP_BEQZ: begin
        w_id_type   = c_T_BR;
        w_id_use_rs = 1'b1;
      end
      c_OP_HLT: w_id_type = c_T_HLT;
      default: ;
    endcase
  end

  // Writeback value; the register file is write-through so ID sees it now
  logic        w_wb_we;
  logic [31:0] w_wb_val;
  assign w_wb_we  = ((r_memwb_type == c_T_RR) || (r_memwb_type == c_T_RI) ||
                     (r_memwb_type == c_T_LD)) && (r_memwb_dst != 5'd0);
  assign w_wb_val = (r_memwb_type == c_T_LD) ? r_memwb_lmd : r_memwb_alu;

  assign w_id_a = (w_id_rs == 5'd0) ? 32'd0 :
                  (w_wb_we && (r_memwb_dst == w_id_rs)) ? w_wb_val : Reg[w_id_rs];
  assign w_id_b = (w_id_rt == 5'd0) ? 32'd0 :
                  (w_wb_we && (r_memwb_dst == w_id_rt)) ? w_wb_val : Reg[w_id_rt];

  // Load-use: the load in EX cannot forward its data in time
  logic w_stall;
  assign w_stall = (r_idex_type == c_T_LD) && (r_idex_dst != 5'd0) &&
                   ((w_id_use_rs && (r_idex_dst == w_id_rs)) ||
                    (w_id_use_rt && (r_idex_dst == w_id_rt)));

  // EX stage with forwarding (EX/MEM has priority as the younger result)
  logic        w_exmem_fwd, w_ex_cond;
  logic [31:0] w_ex_a, w_ex_b, w_ex_op2, w_ex_alu;
  assign w_exmem_fwd = ((r_exmem_type == c_T_RR) || (r_exmem_type == c_T_RI)) &&
                       (r_exmem_dst != 5'd0);
  assign w_ex_a = (w_exmem_fwd && (r_exmem_dst == r_idex_rs)) ? r_exmem_alu :
                  (w_wb_we && (r_memwb_dst == r_idex_rs)) ? w_wb_val : r_idex_a;
  assign w_ex_b = (w_exmem_fwd && (r_exmem_dst == r_idex_rt)) ? r_exmem_alu :
                  (w_wb_we && (r_memwb_dst == r_idex_rt)) ? w_wb_val : r_idex_b;
  assign w_ex_op2  = r_idex_use_imm ? r_idex_imm : w_ex_b;
  assign w_ex_cond = r_idex_bnez ? (w_ex_a != 32'd0) : (w_ex_a == 32'd0);

  always_comb begin
    w_ex_alu = 32'd0;
    case (r_idex_func)
      c_F_ADD: w_ex_alu = w_ex_a + w_ex_op2;
      c_F_SUB: w_ex_alu = w_ex_a - w_ex_op2;
      c_F_AND: w_ex_alu = w_ex_a & w_ex_op2;
      c_F_OR:  w_ex_alu = w_ex_a | w_ex_op2;
      c_F_SLT: w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(w_ex_op2)};
      c_F_MUL: w_ex_alu = w_ex_a * w_ex_op2;
      default: ;
    endcase
    // Branches carry their target in the ALU result field
    if (r_idex_type == c_T_BR) w_ex_alu = r_idex_npc + r_idex_imm;
  end

  // MEM stage: branch resolution and data read
  logic        w_taken;
  logic [31:0] w_mem_rdata, w_fetch_addr, w_fetch_npc, w_fetch_ir;
  assign w_taken      = (r_exmem_type == c_T_BR) && r_exmem_cond;
  assign w_mem_rdata  = Mem[r_exmem_alu[c_AW-1:0]];
  // A taken branch redirects fetch in the same cycle it resolves
  assign w_fetch_addr = w_taken ? r_exmem_alu : PC;
  assign w_fetch_npc  = w_fetch_addr + 32'd1;
  assign w_fetch_ir   = Mem[w_fetch_addr[c_AW-1:0]];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC             <= PC_RESET;
      HALTED         <= 1'b0;
      TAKEN_BRANCH   <= 1'b0;
      r_ifid_ir      <= c_NOP_IR;
      r_ifid_npc     <= 32'd0;
      r_idex_type    <= c_T_NOP;
      r_idex_func    <= c_F_ADD;
      r_idex_bnez    <= 1'b0;
      r_idex_use_imm <= 1'b0;
      r_idex_rs      <= 5'd0;
      r_idex_rt      <= 5'd0;
      r_idex_dst     <= 5'd0;
      r_idex_a       <= 32'd0;
      r_idex_b       <= 32'd0;
      r_idex_imm     <= 32'd0;
      r_idex_npc     <= 32'd0;
      r_exmem_type   <= c_T_NOP;
      r_exmem_dst    <= 5'd0;
      r_exmem_alu    <= 32'd0;
      r_exmem_b      <= 32'd0;
      r_exmem_cond   <= 1'b0;
      r_memwb_type   <= c_T_NOP;
      r_memwb_dst    <= 5'd0;
      r_memwb_alu    <= 32'd0;
      r_memwb_lmd    <= 32'd0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      if (r_exmem_type == c_T_HLT) HALTED <= 1'b1;

      r_memwb_type <= r_exmem_type;
      r_memwb_dst  <= r_exmem_dst;
      r_memwb_alu  <= r_exmem_alu;
      r_memwb_lmd  <= w_mem_rdata;

      r_exmem_type <= w_taken ? c_T_NOP : r_idex_type;
      r_exmem_dst  <= r_idex_dst;
      r_exmem_alu  <= w_ex_alu;
      r_exmem_b    <= w_ex_b;
      r_exmem_cond <= w_ex_cond;

      // Flush takes priority over a coincident load-use stall
      r_idex_type    <= (w_taken || w_stall) ? c_T_NOP : w_id_type;
      r_idex_func    <= w_id_func;
      r_idex_bnez    <= (w_id_op == c_OP_BNEQZ);
      r_idex_use_imm <= w_id_use_imm;
      r_idex_rs      <= w_id_rs;
      r_idex_rt      <= w_id_rt;
      r_idex_dst     <= w_id_dst;
      r_idex_a       <= w_id_a;
      r_idex_b       <= w_id_b;
      r_idex_imm     <= w_id_imm;
      r_idex_npc     <= r_ifid_npc;

      if (w_taken || !w_stall) begin
        PC         <= w_fetch_npc;
        r_ifid_ir  <= w_fetch_ir;
        r_ifid_npc <= w_fetch_npc;
      end
    end
  end

  // Register file and memory are never cleared by reset
  always_ff @(posedge clk1) begin
    if (!HALTED && w_wb_we) Reg[r_memwb_dst] <= w_wb_val;
    if (!HALTED && (r_exmem_type == c_T_ST)) Mem[r_exmem_alu[c_AW-1:0]] <= r_exmem_b;
  end

  assign halted = HALTED;

endmodule
`default_nettype wire

// File: tb/tb_processor_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_32_bit
// Purpose  : Self-checking bench for processor_32_bit: directed programs plus
//            random programs compared against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_32_bit;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halted;

  processor_32_bit #(.MEM_DEPTH(1024), .PC_RESET(32'd0)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .halted(halted)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [5:0] c_ADD = 6'b000000, c_SUB = 6'b000001, c_AND = 6'b000010;
  localparam logic [5:0] c_OR = 6'b000011, c_SLT = 6'b000100, c_MUL = 6'b000101;
  localparam logic [5:0] c_LW = 6'b001000, c_SW = 6'b001001, c_ADDI = 6'b001010;
  localparam logic [5:0] c_SUBI = 6'b001011, c_SLTI = 6'b001100;
  localparam logic [5:0] c_BNEQZ = 6'b001101, c_BEQZ = 6'b001110;
  localparam logic [31:0] c_HLT = 32'hFC00_0000;

  logic [31:0] m_mem [0:1023];
  logic [31:0] m_reg [0:31];
  logic [31:0] prog [$];

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0] s, t;
    logic [15:0] i16;
    s = rs[4:0]; t = rt[4:0]; i16 = imm[15:0];
    return {op, s, t, i16};
  endfunction

  // Hold reset, clear memory, Reg[k]=k, then load prog at address 0
  task automatic setup_program();
    rst_n = 1'b0;
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    foreach (prog[i]) dut.Mem[i] = prog[i];
  endtask

  task automatic release_reset();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cycles, output int cycles);
    cycles = 0;
    while (halted !== 1'b1 && cycles < max_cycles) begin
      @(negedge clk1);
      cycles++;
    end
  endtask

  // Sequential instruction-set interpreter over m_mem/m_reg
  task automatic model_run();
    logic [31:0] pc, ins, a, b, imm, v;
    logic [4:0]  d;
    logic        we;
    pc = 32'd0;
    for (int steps = 0; steps < 4000; steps++) begin
      ins = m_mem[pc[9:0]];
      a   = (ins[25:21] == 5'd0) ? 32'd0 : m_reg[ins[25:21]];
      b   = (ins[20:16] == 5'd0) ? 32'd0 : m_reg[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      pc  = pc + 32'd1;
      we  = 1'b1; d = ins[20:16]; v = 32'd0;
      case (ins[31:26])
        c_ADD:  begin d = ins[15:11]; v = a + b; end
        c_SUB:  begin d = ins[15:11]; v = a - b; end
        c_AND:  begin d = ins[15:11]; v = a & b; end
        c_OR:   begin d = ins[15:11]; v = a | b; end
        c_SLT:  begin d = ins[15:11]; v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        c_MUL:  begin d = ins[15:11]; v = a * b; end
        c_ADDI: v = a + imm;
        c_SUBI: v = a - imm;
        c_SLTI: v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        c_LW:   v = m_mem[(a + imm) % 1024];
        c_SW:   begin we = 1'b0; m_mem[(a + imm) % 1024] = b; end
        c_BNEQZ: begin we = 1'b0; if (a != 0) pc = pc + imm; end
        c_BEQZ:  begin we = 1'b0; if (a == 0) pc = pc + imm; end
        6'b111111: break;
        default: we = 1'b0;
      endcase
      if (we && d != 5'd0) m_reg[d] = v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    dut.Reg[5] = 32'd55;
    repeat (3) @(negedge clk1);
    n_checks++; if (dut.PC !== 32'd0) $display("FAIL reset_pc: got %0d expected 0", dut.PC); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else n_pass++;
    n_checks++; if (dut.TAKEN_BRANCH !== 1'b0) $display("FAIL reset_taken: got %b expected 0", dut.TAKEN_BRANCH); else n_pass++;
    n_checks++; if (dut.Reg[5] !== 32'd55) $display("FAIL reset_no_write: got %0d expected 55", dut.Reg[5]); else n_pass++;
  endtask

  task automatic load_main_program();
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    setup_program();
    dut.Mem[120] = 32'd99;
  endtask

  task automatic test_main_program();
    load_main_program();
    release_reset();
    repeat (30) @(negedge clk1);
    n_checks++; if (dut.Reg[0] !== 32'd0) $display("FAIL main_r0: got %0d expected 0", dut.Reg[0]); else n_pass++;
    n_checks++; if (dut.Reg[1] !== 32'd120) $display("FAIL main_r1: got %0d expected 120", dut.Reg[1]); else n_pass++;
    n_checks++; if (dut.Reg[2] !== 32'd144) $display("FAIL main_r2: got %0d expected 144", dut.Reg[2]); else n_pass++;
    n_checks++; if (dut.Mem[120] !== 32'd99) $display("FAIL main_m120: got %0d expected 99", dut.Mem[120]); else n_pass++;
    n_checks++; if (dut.Mem[121] !== 32'd144) $display("FAIL main_m121: got %0d expected 144", dut.Mem[121]); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL main_halted: got %b expected 1", halted); else n_pass++;
  endtask

  // Counts cycles where PC did not advance before the halt
  task automatic count_pc_stalls(output int stalls, output int cyc);
    logic [31:0] prev;
    stalls = 0; cyc = 0;
    prev = dut.PC;
    while (cyc < 60) begin
      @(negedge clk1);
      cyc++;
      if (halted === 1'b1) break;
      if (dut.PC === prev) stalls++;
      prev = dut.PC;
    end
  endtask

  task automatic test_back_to_back();
    int stalls, cyc;
    prog = '{ri(c_ADDI, 1, 0, 5), rr(c_ADD, 2, 1, 1), rr(c_SUB, 3, 2, 1), c_HLT};
    setup_program();
    release_reset();
    count_pc_stalls(stalls, cyc);
    n_checks++; if (halted !== 1'b1) $display("FAIL b2b_timeout: halted %b expected 1", halted); else n_pass++;
    n_checks++; if (dut.Reg[2] !== 32'd10) $display("FAIL b2b_r2: got %0d expected 10", dut.Reg[2]); else n_pass++;
    n_checks++; if (dut.Reg[3] !== 32'd5) $display("FAIL b2b_r3: got %0d expected 5", dut.Reg[3]); else n_pass++;
    n_checks++; if (stalls !== 0) $display("FAIL b2b_stalls: got %0d expected 0", stalls); else n_pass++;
  endtask

  task automatic test_load_use();
    int stalls, cyc;
    prog = '{ri(c_LW, 4, 0, 10), ri(c_ADDI, 5, 4, 1), c_HLT};
    setup_program();
    dut.Mem[10] = 32'd7;
    release_reset();
    count_pc_stalls(stalls, cyc);
    n_checks++; if (halted !== 1'b1) $display("FAIL lu_timeout: halted %b expected 1", halted); else n_pass++;
    n_checks++; if (dut.Reg[4] !== 32'd7) $display("FAIL lu_r4: got %0d expected 7", dut.Reg[4]); else n_pass++;
    n_checks++; if (dut.Reg[5] !== 32'd8) $display("FAIL lu_r5: got %0d expected 8", dut.Reg[5]); else n_pass++;
    n_checks++; if (stalls !== 1) $display("FAIL lu_stalls: got %0d expected 1", stalls); else n_pass++;
  endtask

  task automatic test_branch_loop();
    int taken_cycles, early, cyc;
    prog = '{ri(c_ADDI, 1, 0, 3), ri(c_SUBI, 1, 1, 1), ri(c_BNEQZ, 0, 1, -2),
             ri(c_ADDI, 6, 0, 1), c_HLT};
    setup_program();
    dut.Reg[6] = 32'd66;
    release_reset();
    taken_cycles = 0; early = 0; cyc = 0;
    while (halted !== 1'b1 && cyc < 80) begin
      @(negedge clk1);
      cyc++;
      if (dut.TAKEN_BRANCH === 1'b1) taken_cycles++;
      if (dut.Reg[6] !== 32'd66 && dut.Reg[1] !== 32'd0) early++;
    end
    n_checks++; if (halted !== 1'b1) $display("FAIL loop_timeout: halted %b expected 1", halted); else n_pass++;
    n_checks++; if (dut.Reg[1] !== 32'd0) $display("FAIL loop_r1: got %0d expected 0", dut.Reg[1]); else n_pass++;
    n_checks++; if (dut.Reg[6] !== 32'd1) $display("FAIL loop_r6: got %0d expected 1", dut.Reg[6]); else n_pass++;
    n_checks++; if (early !== 0) $display("FAIL loop_squash: got %0d early writes expected 0", early); else n_pass++;
    n_checks++; if (taken_cycles !== 2) $display("FAIL loop_taken_pulses: got %0d expected 2", taken_cycles); else n_pass++;
  endtask

  // Taken branch resolving while a load-use pair sits behind it
  task automatic test_branch_squash();
    int cyc;
    prog = '{ri(c_BEQZ, 0, 0, 3), ri(c_LW, 7, 0, 10), rr(c_ADD, 8, 7, 7),
             ri(c_ADDI, 11, 0, 1), ri(c_ADDI, 9, 0, 1), c_HLT};
    setup_program();
    dut.Mem[10] = 32'd5;
    release_reset();
    run_until_halt(80, cyc);
    n_checks++; if (halted !== 1'b1) $display("FAIL squash_timeout: halted %b expected 1", halted); else n_pass++;
    n_checks++; if (dut.Reg[7] !== 32'd7) $display("FAIL squash_r7: got %0d expected 7", dut.Reg[7]); else n_pass++;
    n_checks++; if (dut.Reg[8] !== 32'd8) $display("FAIL squash_r8: got %0d expected 8", dut.Reg[8]); else n_pass++;
    n_checks++; if (dut.Reg[11] !== 32'd11) $display("FAIL squash_r11: got %0d expected 11", dut.Reg[11]); else n_pass++;
    n_checks++; if (dut.Reg[9] !== 32'd1) $display("FAIL squash_r9: got %0d expected 1", dut.Reg[9]); else n_pass++;
  endtask

  task automatic test_halt_freeze();
    int cyc, pc_changes;
    logic [31:0] pc0;
    prog = '{ri(c_ADDI, 2, 0, 77), c_HLT, ri(c_SW, 2, 0, 50)};
    setup_program();
    dut.Mem[50] = 32'd1234;
    release_reset();
    run_until_halt(80, cyc);
    n_checks++; if (halted !== 1'b1) $display("FAIL freeze_timeout: halted %b expected 1", halted); else n_pass++;
    pc0 = dut.PC;
    pc_changes = 0;
    repeat (10) begin
      @(negedge clk1);
      if (dut.PC !== pc0) pc_changes++;
    end
    n_checks++; if (pc_changes !== 0) $display("FAIL freeze_pc: got %0d changes expected 0", pc_changes); else n_pass++;
    n_checks++; if (dut.Mem[50] !== 32'd1234) $display("FAIL freeze_mem50: got %0d expected 1234", dut.Mem[50]); else n_pass++;
    n_checks++; if (dut.Reg[2] !== 32'd77) $display("FAIL freeze_r2: got %0d expected 77", dut.Reg[2]); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL freeze_halted: got %b expected 1", halted); else n_pass++;
  endtask

  task automatic test_async_reset();
    load_main_program();
    release_reset();
    repeat (6) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dut.PC !== 32'd0) $display("FAIL async_pc: got %0d expected 0", dut.PC); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL async_halted: got %b expected 0", halted); else n_pass++;
    repeat (2) @(negedge clk1);
    n_checks++; if (dut.Reg[1] !== 32'd120) $display("FAIL async_keep_r1: got %0d expected 120", dut.Reg[1]); else n_pass++;
    n_checks++; if (dut.Mem[120] !== 32'd99) $display("FAIL async_keep_m120: got %0d expected 99", dut.Mem[120]); else n_pass++;
    rst_n = 1'b1;
    repeat (30) @(negedge clk1);
    n_checks++; if (dut.Reg[2] !== 32'd144) $display("FAIL async_rerun_r2: got %0d expected 144", dut.Reg[2]); else n_pass++;
    n_checks++; if (dut.Mem[121] !== 32'd144) $display("FAIL async_rerun_m121: got %0d expected 144", dut.Mem[121]); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL async_rerun_halted: got %b expected 1", halted); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0) $display("FAIL async_clear_halted: got %b expected 0", halted); else n_pass++;
  endtask

  task automatic test_random_programs();
    logic [5:0] rr_ops [6];
    logic [5:0] ri_ops [3];
    int len, kind, rs, rt, rd, imm, cyc;
    rr_ops = '{c_ADD, c_SUB, c_AND, c_OR, c_SLT, c_MUL};
    ri_ops = '{c_ADDI, c_SUBI, c_SLTI};
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(8, 20);
      prog.delete();
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 9);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        case (kind)
          0, 1, 2: prog.push_back(rr(rr_ops[$urandom_range(0, 5)], rd, rs, rt));
          3, 4:    prog.push_back(ri(ri_ops[$urandom_range(0, 2)], rt, rs, $urandom_range(0, 65535)));
          5, 6:    prog.push_back(ri(c_LW, rt, 0, 200 + $urandom_range(0, 15)));
          7:       prog.push_back(ri(c_SW, rt, 0, 200 + $urandom_range(0, 15)));
          default: begin
            imm = $urandom_range(0, 2);
            if (i + 1 + imm > len) imm = len - i - 1;
            prog.push_back(ri(($urandom_range(0, 1) == 1) ? c_BEQZ : c_BNEQZ, 0, rs, imm));
          end
        endcase
      end
      prog.push_back(c_HLT);
      prog.push_back(ri(c_SW, 3, 0, 200 + $urandom_range(0, 15)));
      prog.push_back(ri(c_ADDI, 5, 5, 1));
      setup_program();
      for (int k = 1; k < 32; k++) dut.Reg[k] = $urandom;
      dut.Reg[0] = 32'd0;
      for (int a = 200; a < 216; a++) dut.Mem[a] = $urandom;
      for (int a = 0; a < 1024; a++) m_mem[a] = dut.Mem[a];
      for (int k = 0; k < 32; k++) m_reg[k] = dut.Reg[k];
      model_run();
      release_reset();
      run_until_halt(400, cyc);
      n_checks++; if (halted !== 1'b1) $display("FAIL rand%0d_halt: halted %b expected 1", p, halted); else n_pass++;
      for (int k = 0; k < 32; k++) begin
        n_checks++;
        if (dut.Reg[k] !== m_reg[k]) $display("FAIL rand%0d_reg%0d: got %h expected %h", p, k, dut.Reg[k], m_reg[k]);
        else n_pass++;
      end
      for (int a = 200; a < 216; a++) begin
        n_checks++;
        if (dut.Mem[a] !== m_mem[a]) $display("FAIL rand%0d_mem%0d: got %h expected %h", p, a, dut.Mem[a], m_mem[a]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_program();
    test_back_to_back();
    test_load_use();
    test_branch_loop();
    test_branch_squash();
    test_halt_freeze();
    test_async_reset();
    test_random_programs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
